// File: rtl/complement_unit_pkg.sv
// rtl/complement_unit_pkg.sv - shared mode and state encodings for complement_unit
package complement_unit_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_ONES = 2'b01,
        MODE_NEG  = 2'b10,
        MODE_ABS  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/complement_unit_if.sv
// rtl/complement_unit_if.sv - request/result bundle between a client and complement_unit
interface complement_unit_if #(parameter int WIDTH = 8);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] Output;
    logic             ready;
    logic             busy;
    logic             overflow;

    modport master (output en, mode, A, input Output, ready, busy, overflow);
    modport slave  (input en, mode, A, output Output, ready, busy, overflow);
endinterface

// File: rtl/complement_unit_chunk_adder.sv
// rtl/complement_unit_chunk_adder.sv - one slice of conditional-invert plus carry-in
module complement_unit_chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] slice,
    input  logic             invert,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out
);
    logic [CHUNK-1:0] operand;

    assign operand      = invert ? ~slice : slice;
    assign {c_out, sum} = {1'b0, operand} + {{CHUNK{1'b0}}, c_in};
endmodule

// File: rtl/complement_unit.sv
// rtl/complement_unit.sv - slice-serial pass/ones/negate/abs unit with overflow flag
module complement_unit
    import complement_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    complement_unit_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             inv_q, inv_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic [CHUNK-1:0] slice;
    logic [CHUNK-1:0] sum;
    logic             c_out;

    assign slice = op_q[int'(idx_q) * CHUNK +: CHUNK];

    complement_unit_chunk_adder #(.CHUNK(CHUNK)) u_adder (
        .slice  (slice),
        .invert (inv_q),
        .c_in   (carry_q),
        .sum    (sum),
        .c_out  (c_out)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        op_d     = op_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        idx_d    = idx_q;
        inv_d    = inv_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        ready_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    op_d    = bus.A;
                    mode_d  = mode_e'(bus.mode);
                    idx_d   = '0;
                    state_d = S_RUN;
                    // abs is negate-if-negative: invert and +1 both follow the sign bit
                    case (mode_e'(bus.mode))
                        MODE_PASS: begin inv_d = 1'b0; carry_d = 1'b0; end
                        MODE_ONES: begin inv_d = 1'b1; carry_d = 1'b0; end
                        MODE_NEG:  begin inv_d = 1'b1; carry_d = 1'b1; end
                        default:   begin inv_d = bus.A[WIDTH-1]; carry_d = bus.A[WIDTH-1]; end
                    endcase
                end
            end
            S_RUN: begin
                shadow_d[int'(idx_q) * CHUNK +: CHUNK] = sum;
                carry_d = c_out;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    out_d   = shadow_d;
                    ovf_d   = ((mode_q == MODE_NEG) || (mode_q == MODE_ABS)) && (op_q == MOST_NEG);
                    ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_PASS;
            op_q     <= '0;
            shadow_q <= '0;
            out_q    <= '0;
            idx_q    <= '0;
            inv_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            op_q     <= op_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            idx_q    <= idx_d;
            inv_q    <= inv_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.Output   = out_q;
    assign bus.overflow = ovf_q;
    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
endmodule
